// File: rtl/lsd_alu_pkg.sv
// lsd_alu_pkg: shared constants for the LSD lab processor ALU.
// Opcode encodings, flag bit positions and datapath widths used by
// lsd_alu, lsd_alu_addsub and anything that decodes into the ALU.
package lsd_alu_pkg;

    localparam int DATA_W = 8;
    localparam int OPR_W  = 3;
    localparam int FLAG_W = 4;

    // Operation select encodings
    localparam logic [OPR_W-1:0] OP_PASSB = 3'b000;
    localparam logic [OPR_W-1:0] OP_SUB   = 3'b001;
    localparam logic [OPR_W-1:0] OP_ADD   = 3'b010;
    localparam logic [OPR_W-1:0] OP_XOR   = 3'b011;
    localparam logic [OPR_W-1:0] OP_SHR   = 3'b100;
    localparam logic [OPR_W-1:0] OP_SHL   = 3'b101;
    localparam logic [OPR_W-1:0] OP_AND   = 3'b110;
    localparam logic [OPR_W-1:0] OP_OR    = 3'b111;

    // Bit positions inside FLAGS
    localparam int FLAG_OVFL  = 3;
    localparam int FLAG_CARRY = 2;
    localparam int FLAG_NEG   = 1;
    localparam int FLAG_ZERO  = 0;

endpackage

// File: rtl/lsd_alu_if.sv
// lsd_alu_if: operand/result bundle between the operand registers and
// instruction decoder (master) and the ALU (slave).
// There is no valid/ready handshake on this bundle: the slave samples
// A/B/OPR on every rising clock edge and presents R/FLAGS one edge later,
// so every cycle carries exactly one operation.
interface lsd_alu_if;
    import lsd_alu_pkg::*;

    logic [DATA_W-1:0] A;
    logic [DATA_W-1:0] B;
    logic [OPR_W-1:0]  OPR;
    logic [DATA_W-1:0] R;
    logic [FLAG_W-1:0] FLAGS;

    modport master (
        output A,
        output B,
        output OPR,
        input  R,
        input  FLAGS
    );

    modport slave (
        input  A,
        input  B,
        input  OPR,
        output R,
        output FLAGS
    );

endinterface

// File: rtl/lsd_alu_addsub.sv
// lsd_alu_addsub: combinational 8-bit adder/subtractor shared by the ADD and
// SUB opcodes. Subtraction is A + ~B + 1, so carry means "no borrow"
// (A >= B unsigned) when sub is set.
module lsd_alu_addsub
    import lsd_alu_pkg::*;
(
    input  logic [DATA_W-1:0] A,
    input  logic [DATA_W-1:0] B,
    input  logic              sub,
    output logic [DATA_W-1:0] sum,
    output logic              carry,
    output logic              ovfl
);

    logic [DATA_W-1:0] b_eff;
    logic [DATA_W:0]   full;

    // Invert B and inject the +1 through the carry-in for subtraction; signed
    // overflow occurs when both addends share a sign that the result lacks.
    always_comb begin
        b_eff = sub ? ~B : B;
        full  = {1'b0, A} + {1'b0, b_eff} + {{DATA_W{1'b0}}, sub};
        sum   = full[DATA_W-1:0];
        carry = full[DATA_W];
        ovfl  = (A[DATA_W-1] == b_eff[DATA_W-1]) && (sum[DATA_W-1] != A[DATA_W-1]);
    end

endmodule

// File: rtl/lsd_alu.sv
// lsd_alu: 8-bit, eight-operation ALU with registered result and flags.
// A/B/OPR are sampled every rising edge; R/FLAGS follow one cycle later.
// Build option: define LSD_ALU_SHIFT_CARRY_EN to report the shifted-out bit
// on CARRY for the shift opcodes (otherwise CARRY is 0 for shifts).
module lsd_alu
    import lsd_alu_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    lsd_alu_if.slave   bus
);

    logic [DATA_W-1:0] as_sum;
    logic              as_carry;
    logic              as_ovfl;
    logic              as_sub;

    logic [DATA_W-1:0] res_next;
    logic              carry_next;
    logic              ovfl_next;
    logic [FLAG_W-1:0] flags_next;

    logic [DATA_W-1:0] r_q;
    logic [FLAG_W-1:0] flags_q;

    assign as_sub = (bus.OPR == OP_SUB);

    lsd_alu_addsub u_addsub (
        .A     (bus.A),
        .B     (bus.B),
        .sub   (as_sub),
        .sum   (as_sum),
        .carry (as_carry),
        .ovfl  (as_ovfl)
    );

    // Result mux plus the opcode-dependent CARRY/OVFL sources
    always_comb begin
        res_next   = '0;
        carry_next = 1'b0;
        ovfl_next  = 1'b0;
        case (bus.OPR)
            OP_PASSB: res_next = bus.B;
            OP_SUB, OP_ADD: begin
                res_next   = as_sum;
                carry_next = as_carry;
                ovfl_next  = as_ovfl;
            end
            OP_XOR:   res_next = bus.A ^ bus.B;
            OP_SHR: begin
                res_next = {1'b0, bus.A[DATA_W-1:1]};
`ifdef LSD_ALU_SHIFT_CARRY_EN
                carry_next = bus.A[0];
`else
                carry_next = 1'b0;
`endif
            end
            OP_SHL: begin
                res_next = {bus.A[DATA_W-2:0], 1'b0};
`ifdef LSD_ALU_SHIFT_CARRY_EN
                carry_next = bus.A[DATA_W-1];
`else
                carry_next = 1'b0;
`endif
            end
            OP_AND:   res_next = bus.A & bus.B;
            OP_OR:    res_next = bus.A | bus.B;
            default:  res_next = '0;
        endcase
    end

    // Assemble the flag vector; ZERO and NEG derive from the result for all opcodes
    always_comb begin
        flags_next             = '0;
        flags_next[FLAG_OVFL]  = ovfl_next;
        flags_next[FLAG_CARRY] = carry_next;
        flags_next[FLAG_NEG]   = res_next[DATA_W-1];
        flags_next[FLAG_ZERO]  = (res_next == '0);
    end

    // Output registers: cleared asynchronously, loaded every cycle otherwise
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q     <= '0;
            flags_q <= '0;
        end else begin
            r_q     <= res_next;
            flags_q <= flags_next;
        end
    end

    assign bus.R     = r_q;
    assign bus.FLAGS = flags_q;

endmodule

// File: tb/tb_lsd_alu.sv
// tb_lsd_alu: directed self-checking bench for lsd_alu. Expected values are
// hand-computed; shift CARRY expectations follow LSD_ALU_SHIFT_CARRY_EN.
module tb_lsd_alu;
    import lsd_alu_pkg::*;

`ifdef LSD_ALU_SHIFT_CARRY_EN
    localparam bit SC = 1'b1;
`else
    localparam bit SC = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    lsd_alu_if bus ();

    lsd_alu dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // ---------------- driver tasks ----------------
    task automatic drive(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
        @(negedge clk);
        bus.A   = a;
        bus.B   = b;
        bus.OPR = op;
    endtask

    task automatic settle;
        @(posedge clk);
        #1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset;
        bus.A   = 8'hFF;
        bus.B   = 8'h02;
        bus.OPR = OP_ADD;
        rst_n   = 1'b1;
        #12;                       // between edges: one edge has loaded FF+02
        rst_n = 1'b0;
        #1;
        total++;
        if (bus.R !== 8'h00 || bus.FLAGS !== 4'b0000) begin
            bad++;
            $display("FAIL reset_async: R=%h FLAGS=%b, expected R=00 FLAGS=0000", bus.R, bus.FLAGS);
        end
        settle();
        total++;
        if (bus.R !== 8'h00 || bus.FLAGS !== 4'b0000) begin
            bad++;
            $display("FAIL reset_hold: R=%h FLAGS=%b, expected R=00 FLAGS=0000", bus.R, bus.FLAGS);
        end
        @(negedge clk);
        rst_n = 1'b1;
        settle();
        total++;
        if (bus.R !== 8'h01 || bus.FLAGS !== 4'b0100) begin
            bad++;
            $display("FAIL reset_release: R=%h FLAGS=%b, expected R=01 FLAGS=0100", bus.R, bus.FLAGS);
        end
    endtask

    task automatic test_logic;
        logic [7:0] va [0:3];
        logic [7:0] vb [0:3];
        logic [2:0] vo [0:3];
        logic [7:0] er [0:3];
        logic [3:0] ef [0:3];
        va = '{8'hF2, 8'hA5, 8'hA0, 8'h00};
        vb = '{8'hE9, 8'hAA, 8'hAA, 8'h0F};
        vo = '{OP_PASSB, OP_XOR, OP_AND, OP_OR};
        er = '{8'hE9, 8'h0F, 8'hA0, 8'h0F};
        ef = '{4'b0010, 4'b0000, 4'b0010, 4'b0000};
        for (int i = 0; i < 4; i++) begin
            drive(va[i], vb[i], vo[i]);
            settle();
            total++;
            if (bus.R !== er[i] || bus.FLAGS !== ef[i]) begin
                bad++;
                $display("FAIL logic[%0d] opr=%0d: R=%h FLAGS=%b, expected R=%h FLAGS=%b",
                         i, vo[i], bus.R, bus.FLAGS, er[i], ef[i]);
            end
        end
    endtask

    task automatic test_add_sub;
        logic [7:0] va [0:4];
        logic [7:0] vb [0:4];
        logic [2:0] vo [0:4];
        logic [7:0] er [0:4];
        logic [3:0] ef [0:4];
        va = '{8'd112, 8'd64,  8'd10,  8'd10,  8'd10};
        vb = '{8'd32,  8'hFF,  8'd10,  8'd12,  8'd3};
        vo = '{OP_ADD, OP_ADD, OP_SUB, OP_SUB, OP_SUB};
        er = '{8'h90,  8'h3F,  8'h00,  8'hFE,  8'h07};
        ef = '{4'b1010, 4'b0100, 4'b0101, 4'b0010, 4'b0100};
        for (int i = 0; i < 5; i++) begin
            drive(va[i], vb[i], vo[i]);
            settle();
            total++;
            if (bus.R !== er[i] || bus.FLAGS !== ef[i]) begin
                bad++;
                $display("FAIL addsub[%0d] opr=%0d: R=%h FLAGS=%b, expected R=%h FLAGS=%b",
                         i, vo[i], bus.R, bus.FLAGS, er[i], ef[i]);
            end
        end
    endtask

    task automatic test_shift;
        logic [7:0] va [0:3];
        logic [2:0] vo [0:3];
        logic [7:0] er [0:3];
        logic [3:0] ef [0:3];
        va = '{8'hDE, 8'd99, 8'h80, 8'h01};
        vo = '{OP_SHR, OP_SHL, OP_SHL, OP_SHR};
        er = '{8'h6F, 8'hC6, 8'h00, 8'h00};
        ef = '{4'b0000, 4'b0010, {1'b0, SC, 2'b01}, {1'b0, SC, 2'b01}};
        for (int i = 0; i < 4; i++) begin
            drive(va[i], 8'h5A, vo[i]);
            settle();
            total++;
            if (bus.R !== er[i] || bus.FLAGS !== ef[i]) begin
                bad++;
                $display("FAIL shift[%0d] opr=%0d: R=%h FLAGS=%b, expected R=%h FLAGS=%b",
                         i, vo[i], bus.R, bus.FLAGS, er[i], ef[i]);
            end
        end
    endtask

    task automatic test_mid_cycle;
        drive(8'd10, 8'd3, OP_ADD);
        settle();
        total++;
        if (bus.R !== 8'h0D || bus.FLAGS !== 4'b0000) begin
            bad++;
            $display("FAIL midcycle_load: R=%h FLAGS=%b, expected R=0D FLAGS=0000", bus.R, bus.FLAGS);
        end
        bus.A   = 8'hF0;
        bus.B   = 8'h0F;
        bus.OPR = OP_OR;
        #3;
        total++;
        if (bus.R !== 8'h0D || bus.FLAGS !== 4'b0000) begin
            bad++;
            $display("FAIL midcycle_hold: R=%h FLAGS=%b, expected R=0D FLAGS=0000", bus.R, bus.FLAGS);
        end
        settle();
        total++;
        if (bus.R !== 8'hFF || bus.FLAGS !== 4'b0010) begin
            bad++;
            $display("FAIL midcycle_next: R=%h FLAGS=%b, expected R=FF FLAGS=0010", bus.R, bus.FLAGS);
        end
    endtask

    task automatic test_back_to_back;
        logic [11:0] exp_q [$];
        logic [11:0] exp_v;
        logic [11:0] prev_v;
        logic [7:0]  va [0:7];
        logic [7:0]  vb [0:7];
        logic [7:0]  er [0:7];
        logic [3:0]  ef [0:7];
        va = '{8'h12, 8'h80, 8'hFF, 8'd112, 8'h01, 8'h41, 8'h0F, 8'h80};
        vb = '{8'h34, 8'h01, 8'h01, 8'd32,  8'h00, 8'h00, 8'hF0, 8'h01};
        er = '{8'h34, 8'h7F, 8'h00, 8'h50,  8'h00, 8'h82, 8'h00, 8'h81};
        ef = '{4'b0000, 4'b1100, 4'b0101, 4'b0000, {1'b0, SC, 2'b01}, 4'b0010, 4'b0001, 4'b0010};
        prev_v = {4'b0010, 8'hFF};     // left over from test_mid_cycle
        for (int i = 0; i < 8; i++) begin
            drive(va[i], vb[i], 3'(i));
            exp_q.push_back({ef[i], er[i]});
            #1;
            total++;
            if ({bus.FLAGS, bus.R} !== prev_v) begin
                bad++;
                $display("FAIL b2b_early[%0d]: R=%h FLAGS=%b, expected R=%h FLAGS=%b",
                         i, bus.R, bus.FLAGS, prev_v[7:0], prev_v[11:8]);
            end
            settle();
            exp_v = exp_q.pop_front();
            total++;
            if ({bus.FLAGS, bus.R} !== exp_v) begin
                bad++;
                $display("FAIL b2b[%0d] opr=%0d: R=%h FLAGS=%b, expected R=%h FLAGS=%b",
                         i, i, bus.R, bus.FLAGS, exp_v[7:0], exp_v[11:8]);
            end
            prev_v = exp_v;
        end
    endtask

    task automatic test_reset_midstream;
        drive(8'd112, 8'd32, OP_ADD);
        settle();
        total++;
        if (bus.R !== 8'h90 || bus.FLAGS !== 4'b1010) begin
            bad++;
            $display("FAIL midreset_pre: R=%h FLAGS=%b, expected R=90 FLAGS=1010", bus.R, bus.FLAGS);
        end
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if (bus.R !== 8'h00 || bus.FLAGS !== 4'b0000) begin
            bad++;
            $display("FAIL midreset_clear: R=%h FLAGS=%b, expected R=00 FLAGS=0000", bus.R, bus.FLAGS);
        end
        @(negedge clk);
        rst_n = 1'b1;
        settle();
        total++;
        if (bus.R !== 8'h90 || bus.FLAGS !== 4'b1010) begin
            bad++;
            $display("FAIL midreset_release: R=%h FLAGS=%b, expected R=90 FLAGS=1010", bus.R, bus.FLAGS);
        end
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #100000;
        $display("FAIL watchdog: time=%0t, expected completion before 100000", $time);
        $fatal(1, "timeout");
    end

    // ---------------- sequence + final report ----------------
    initial begin
        test_reset();
        test_logic();
        test_add_sub();
        test_shift();
        test_mid_cycle();
        test_back_to_back();
        test_reset_midstream();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/lsd_alu.md
# lsd_alu

8-bit, eight-operation arithmetic/logic unit with a 4-bit status flag output, registered on a single clock. Operands and opcode are sampled every rising edge; result and flags appear one cycle later. It is the datapath execution unit of the LSD lab processor and is driven directly by the operand registers and instruction decoder.

## Interface

Parameters:
- none. Data width fixed at 8, opcode width at 3, flag width at 4.

Ports:
- clk  input  1  single clock; all state updates on its rising edge
- rst_n  input  1  asynchronous, active-low reset
- A  input  8  operand A (two's complement or unsigned, per operation)
- B  input  8  operand B
- OPR  input  3  operation select
- R  output  8  registered result
- FLAGS  output  4  registered status: [3]=OVFL, [2]=CARRY, [1]=NEG, [0]=ZERO

## Operation

- Opcodes (result R):
  - 000: R = B
  - 001: R = A − B (mod 256)
  - 010: R = A + B (mod 256)
  - 011: R = A ^ B
  - 100: R = A >> 1, logical (MSB filled with 0)
  - 101: R = A << 1 (LSB filled with 0)
  - 110: R = A & B
  - 111: R = A | B
- ZERO = (R == 0), all opcodes.
- NEG = R[7], all opcodes.
- CARRY:
  - 010: carry out of the 9-bit sum A + B.
  - 001: carry out of A + ~B + 1, i.e. 1 when A ≥ B unsigned (no borrow).
  - All other opcodes: 0, unless the configuration macro below is defined.
- OVFL:
  - 010: A[7] == B[7] and R[7] != A[7].
  - 001: A[7] != B[7] and R[7] != A[7].
  - All other opcodes: 0.
- No other side effects. No enable: a new result is registered every cycle.

## Timing

- Reset (rst_n low, asynchronous): R = 8'h00 and FLAGS = 4'b0000 immediately, held until release.
- After release, the first rising edge registers the computation of the current A/B/OPR.
- Latency is exactly 1 cycle. Inputs present before edge n appear on R/FLAGS after edge n. Throughput is one operation per cycle.
- Inputs changing mid-cycle have no effect on outputs until the next edge.
- Reset asserted mid-stream clears outputs at once. No pending result survives reset.

## Configuration

- LSD_ALU_SHIFT_CARRY_EN defined: for opcode 100, CARRY = A[0]; for opcode 101, CARRY = A[7] (the shifted-out bit).
- Not defined: CARRY = 0 for both shift opcodes.
- All other behaviour is identical in both builds.

## Structure

- Package lsd_alu_pkg holds:
  - opcode localparams: OP_PASSB, OP_SUB, OP_ADD, OP_XOR, OP_SHR, OP_SHL, OP_AND, OP_OR
  - flag bit indices: FLAG_OVFL=3, FLAG_CARRY=2, FLAG_NEG=1, FLAG_ZERO=0
  - the data width constant (8)
- Sub-module lsd_alu_addsub: a combinational 8-bit adder/subtractor.
  - Inputs: A, B, and sub.
  - Outputs: sum, carry, and ovfl.
  - Used for both opcodes 001 and 010.
- The top level contains the result mux, flag logic and output registers.

## Test plan

- Reset: assert rst_n=0 with A=8'hFF, OPR=010 → R=0, FLAGS=0000 with no clock edge needed. Release → next edge computes normally.
- Pass/logic ops, one cycle after each edge:
  - OPR=000, A=−14, B=−23 → R=8'hE9, FLAGS=0010.
  - OPR=011, A=8'hA5, B=8'hAA → R=8'h0F, FLAGS=0000.
  - OPR=110, A=8'hA0, B=8'hAA → R=8'hA0, FLAGS=0010.
  - OPR=111, A=8'h00, B=8'h0F → R=8'h0F, FLAGS=0000.
- Add:
  - A=112, B=32 → R=8'h90, FLAGS=1010 (OVFL, NEG).
  - A=64, B=−1 → R=8'h3F, FLAGS=0100 (CARRY).
- Subtract:
  - A=10, B=10 → R=0, FLAGS=0101.
  - A=10, B=12 → R=8'hFE, FLAGS=0010.
  - A=10, B=3 → R=7, FLAGS=0100.
- Shifts:
  - OPR=100, A=−34 (8'hDE) → R=8'h6F, FLAGS=0000 in both builds (A[0]=0).
  - OPR=101, A=99 → R=8'hC6, FLAGS=0010.
  - OPR=101, A=8'h80 → R=0, FLAGS=0001 without the macro, 0101 with LSD_ALU_SHIFT_CARRY_EN.
- Back-to-back: change OPR and operands every cycle through all 8 opcodes → each result appears exactly one edge later. XOR with A=112, B=32 gives OVFL=CARRY=0.
